// File: rtl/beat_timing_gen.sv
// Beat/phase timing generator: one-hot phases T1..T3 and beats W[3:1] for the hardwired CPU.
// Optional single-step halt via DP is enabled by defining SINGLE_STEP_EN.
module beat_timing_gen #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       QD,
  input  logic       DP,
  input  logic       SHORT,
  input  logic       LONG,
  input  logic       STOP,
  output logic       T1,
  output logic       T2,
  output logic       T3,
  output logic [2:0] W,
  output logic       RUN
);

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_T1   = 2'd1,
    PH_T2   = 2'd2,
    PH_T3   = 2'd3
  } phase_e;

  phase_e ph_q, ph_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   qd_rise;

  logic [2:0] w_q, w_d, w_next;
  logic       t1_q, t2_q, t3_q, run_q;
  logic       halt;
  logic       step_halt;

`ifdef SINGLE_STEP_EN
  assign step_halt = DP;
`else
  logic unused_dp;
  assign unused_dp = DP;
  assign step_halt = 1'b0;
`endif

  // QD synchroniser followed by a rising-edge detector
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], QD};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign qd_rise = sync_q[SYNC_STAGES-1] & ~edge_q;
  assign halt    = STOP | step_halt;

  always_comb begin
    w_next = 3'b001;
    unique case (w_q)
      3'b001:  w_next = SHORT ? 3'b001 : 3'b010;
      3'b010:  w_next = LONG  ? 3'b100 : 3'b001;
      3'b100:  w_next = 3'b001;
      default: w_next = 3'b001;
    endcase
  end

  always_comb begin
    ph_d = ph_q;
    w_d  = w_q;
    unique case (ph_q)
      PH_IDLE: if (qd_rise) ph_d = PH_T1;
      PH_T1:   ph_d = PH_T2;
      PH_T2:   ph_d = PH_T3;
      PH_T3: begin
        // W advances even when this beat halts, so the next start runs the new beat
        w_d  = w_next;
        ph_d = halt ? PH_IDLE : PH_T1;
      end
      default: ph_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      ph_q  <= PH_IDLE;
      w_q   <= 3'b001;
      t1_q  <= 1'b0;
      t2_q  <= 1'b0;
      t3_q  <= 1'b0;
      run_q <= 1'b0;
    end else begin
      ph_q  <= ph_d;
      w_q   <= w_d;
      t1_q  <= (ph_d == PH_T1);
      t2_q  <= (ph_d == PH_T2);
      t3_q  <= (ph_d == PH_T3);
      run_q <= (ph_d != PH_IDLE);
    end
  end

  assign T1  = t1_q;
  assign T2  = t2_q;
  assign T3  = t3_q;
  assign W   = w_q;
  assign RUN = run_q;

endmodule

// File: tb/tb_beat_timing_gen.sv
// Scoreboard bench for beat_timing_gen: a cycle model predicts outputs per edge.
module tb_beat_timing_gen;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       QD = 1'b0, DP = 1'b0, SHORT = 1'b0, LONG = 1'b0, STOP = 1'b0;
  logic       T1, T2, T3, RUN;
  logic [2:0] W;
  logic       clr_drive = 1'b1;

  beat_timing_gen #(.SYNC_STAGES(2)) dut (
    .CLK(CLK), .CLR(CLR), .QD(QD), .DP(DP), .SHORT(SHORT), .LONG(LONG), .STOP(STOP),
    .T1(T1), .T2(T2), .T3(T3), .W(W), .RUN(RUN)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;
  logic [6:0] exp_q[$];

  logic       m_s0, m_s1, m_edge, m_run;
  int         m_ph;
  logic [2:0] m_w;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_s0 = 1'b0; m_s1 = 1'b0; m_edge = 1'b0;
    m_run = 1'b0; m_ph = 0; m_w = 3'b001;
  endtask

  function automatic logic [6:0] m_pack();
    return {m_ph == 1, m_ph == 2, m_ph == 3, m_w, m_run};
  endfunction

  task automatic m_clock();
    logic rise, dp_halt;
`ifdef SINGLE_STEP_EN
    dp_halt = DP;
`else
    dp_halt = 1'b0;
`endif
    rise = m_s1 & ~m_edge;
    if (!CLR) begin
      m_reset();
    end else begin
      if (m_run) begin
        if (m_ph == 3) begin
          if (m_w == 3'b001)      m_w = SHORT ? 3'b001 : 3'b010;
          else if (m_w == 3'b010) m_w = LONG ? 3'b100 : 3'b001;
          else                    m_w = 3'b001;
          if (STOP || dp_halt) begin m_run = 1'b0; m_ph = 0; end
          else m_ph = 1;
        end else begin
          m_ph = m_ph + 1;
        end
      end else if (rise) begin
        m_run = 1'b1; m_ph = 1;
      end
      m_edge = m_s1; m_s1 = m_s0; m_s0 = QD;
    end
  endtask

  task automatic step(input string tag, input logic qd, input logic sh, input logic lg,
                      input logic st, input logic dp);
    logic [6:0] e;
    @(negedge CLK);
    CLR = clr_drive; QD = qd; SHORT = sh; LONG = lg; STOP = st; DP = dp;
    m_clock();
    exp_q.push_back(m_pack());
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    check(tag, {T1, T2, T3, W, RUN}, e);
  endtask

  initial begin
    int cnt;
    logic found;
    logic exp_run6;

    // asynchronous reset
    #1 CLR = 1'b0; clr_drive = 1'b0;
    #2 check("reset", {T1, T2, T3, W, RUN}, 7'b000_001_0);
    m_reset();
    step("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clr_drive = 1'b1;

    // test 1: start latency and free run
    step("t1_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t1_run_edge1", RUN, 1'b0);
    step("t1_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t1_run_edge2", RUN, 1'b0);
    step("t1_start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t1_run_edge3", {RUN, T1, W}, 5'b1_1_001);
    for (int i = 0; i < 12; i++) step("t1_free", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // test 2: LONG held; LONG only matters at the end of W2
    cnt = 0;
    for (int i = 0; i < 18; i++) begin
      step("t2_long", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (W == 3'b100) cnt++;
    end
    check("t2_w3_cycles", cnt, 6);

    // test 3: SHORT+STOP in W1, then one beat per press
    for (int i = 0; i < 6; i++) step("t3_halt", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t3_halted", {RUN, W}, 4'b0_001);
    for (int p = 0; p < 3; p++) begin
      cnt = 0;
      for (int i = 0; i < 8; i++) begin
        step("t3_press", (i < 2), 1'b1, 1'b0, 1'b1, 1'b0);
        if (RUN) cnt++;
      end
      check("t3_beat_len", cnt, 3);
      check("t3_w_stays", W, 3'b001);
    end

    // test 4: CLR in T2 of W2
    step("t4_go", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("t4_go", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step("t4_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (m_ph == 2 && m_w == 3'b010) begin found = 1'b1; break; end
    end
    check("t4_reach_w2t2", found, 1'b1);
    #1 CLR = 1'b0; clr_drive = 1'b0;
    #1 check("t4_clr", {T1, T2, T3, W, RUN}, 7'b000_001_0);
    m_reset();
    step("t4_clr_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    clr_drive = 1'b1;
    step("t4_restart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("t4_restart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("t4_restart", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t4_w1t1", {RUN, T1, W}, 5'b1_1_001);

    // test 5: QD held across a halt; press while running
    for (int i = 0; i < 12; i++) step("t5_hold", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t5_no_restart", RUN, 1'b0);
    for (int i = 0; i < 6; i++) step("t5_repress", (i >= 3), 1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_restart", RUN, 1'b1);
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      step("t5_busy_press", (i >= 2 && i < 5), 1'b0, 1'b0, 1'b0, 1'b0);
      if (!RUN) cnt++;
    end
    check("t5_busy_idle_cycles", cnt, 0);

    // test 6: DP single-step (only halts when SINGLE_STEP_EN is defined)
`ifdef SINGLE_STEP_EN
    exp_run6 = 1'b0;
`else
    exp_run6 = 1'b1;
`endif
    for (int i = 0; i < 6; i++) step("t6_dp", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t6_dp_run", RUN, exp_run6);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 8; i++) step("t6_press", (i < 2), 1'b0, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
